// File: rtl/geofence_driver.sv
// geofence_driver
// ----------------------------------------------------------------------------
// Test driver for a geofence receiver. It holds four frames of seven points
// each: point 0 is the object and points 1..6 are the fence vertices. On
// start it streams each frame's points to the receiver on X/Y, one point per
// cycle. It then waits for the receiver's valid/is_inside answer and collects
// the answers into result/inside_cnt.
//
// Optional feature (macro GEOFENCE_TIMEOUT_EN): a WAIT watchdog. If valid does
// not arrive within TIMEOUT cycles, the run aborts with err set.
// When the macro is undefined, WAIT lasts until valid and err is tied to 0.
//
// Ports
//   clk            : single clock, all logic on the rising edge
//   reset          : synchronous, active-low reset
//   wr_en          : frame-memory write strobe (honoured only in IDLE)
//   wr_frame       : frame index 0..3
//   wr_pt          : 0 = object, 1..6 = vertices 0..5, 7 = ignored
//   wr_x, wr_y     : point coordinates
//   num_frames_m1  : frames to run minus 1, sampled with start
//   start          : begin a run (honoured only in IDLE)
//   busy           : high while in SEND or WAIT
//   X, Y           : point stream to the receiver
//   dut_reset      : active-high reset to the receiver
//   valid          : receiver result strobe (honoured only in WAIT)
//   is_inside      : receiver verdict qualified by valid
//   result         : bit f = is_inside of frame f
//   inside_cnt     : number of frames judged inside
//   done           : one-cycle pulse at end of run
//   err            : sticky timeout flag, cleared by start
//   state_dbg      : current FSM state (0 IDLE, 1 SEND, 2 WAIT, 3 DONE)
//
// Handshake: the receiver's answer is accepted on the single rising edge
// where valid=1 while the driver is in WAIT. There is no ready; the driver
// is always able to take the answer in WAIT. valid in any other state is
// dropped.
// ----------------------------------------------------------------------------
module geofence_driver #(
  parameter int TIMEOUT = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [1:0] wr_frame,
  input  logic [2:0] wr_pt,
  input  logic [9:0] wr_x,
  input  logic [9:0] wr_y,
  input  logic [1:0] num_frames_m1,
  input  logic       start,
  output logic       busy,
  output logic [9:0] X,
  output logic [9:0] Y,
  output logic       dut_reset,
  input  logic       valid,
  input  logic       is_inside,
  output logic [3:0] result,
  output logic [2:0] inside_cnt,
  output logic       done,
  output logic       err,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  frame_q, frame_d;
  logic [2:0]  pt_q, pt_d;
  logic [1:0]  nfm_q, nfm_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic        dut_reset_q, dut_reset_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [3:0]  result_q, result_d;
  logic [2:0]  inside_q, inside_d;

  // Frame memory: {x, y} per point.
  logic [19:0] mem_q [0:3][0:6];

  logic [2:0]  pt_inc;
  logic [1:0]  frame_inc;

  assign pt_inc    = pt_q + 3'd1;
  assign frame_inc = frame_q + 2'd1;

`ifdef GEOFENCE_TIMEOUT_EN
  localparam int WCW = $clog2(TIMEOUT + 1);
  logic [WCW-1:0] wait_q, wait_d;
  logic           err_q, err_d;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT);
`endif

  // Frame memory. Writes are only accepted while idle, so a run always
  // streams a stable snapshot.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int f = 0; f < 4; f++) begin
        for (int p = 0; p < 7; p++) begin
          mem_q[f][p] <= '0;
        end
      end
    end else if (wr_en && (state_q == S_IDLE) && (wr_pt != 3'd7)) begin
      mem_q[wr_frame][wr_pt] <= {wr_x, wr_y};
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      frame_q     <= '0;
      pt_q        <= '0;
      nfm_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      dut_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      inside_q    <= '0;
`ifdef GEOFENCE_TIMEOUT_EN
      wait_q      <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      pt_q        <= pt_d;
      nfm_q       <= nfm_d;
      x_q         <= x_d;
      y_q         <= y_d;
      dut_reset_q <= dut_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      result_q    <= result_d;
      inside_q    <= inside_d;
`ifdef GEOFENCE_TIMEOUT_EN
      wait_q      <= wait_d;
      err_q       <= err_d;
`endif
    end
  end

  // Next-state logic. Outputs are computed one cycle ahead so every output
  // port comes straight from a flop.
  always_comb begin
    state_d     = state_q;
    frame_d     = frame_q;
    pt_d        = pt_q;
    nfm_d       = nfm_q;
    x_d         = x_q;
    y_d         = y_q;
    dut_reset_d = dut_reset_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    result_d    = result_q;
    inside_d    = inside_q;
`ifdef GEOFENCE_TIMEOUT_EN
    wait_d      = wait_q;
    err_d       = err_q;
`endif

    case (state_q)
      S_IDLE: begin
        x_d         = '0;
        y_d         = '0;
        dut_reset_d = 1'b1;
        busy_d      = 1'b0;
        if (start) begin
          result_d     = '0;
          inside_d     = '0;
          nfm_d        = num_frames_m1;
          frame_d      = '0;
          pt_d         = '0;
          {x_d, y_d}   = mem_q[0][0];
          dut_reset_d  = 1'b0;
          busy_d       = 1'b1;
          state_d      = S_SEND;
`ifdef GEOFENCE_TIMEOUT_EN
          err_d        = 1'b0;
`endif
        end
      end

      S_SEND: begin
        if (pt_q == 3'd6) begin
          x_d     = '0;
          y_d     = '0;
          state_d = S_WAIT;
`ifdef GEOFENCE_TIMEOUT_EN
          wait_d  = '0;
`endif
        end else begin
          pt_d       = pt_inc;
          {x_d, y_d} = mem_q[frame_q][pt_inc];
        end
      end

      S_WAIT: begin
        if (valid) begin
          result_d[frame_q] = is_inside;
          if (is_inside) begin
            inside_d = inside_q + 3'd1;
          end
          if (frame_q != nfm_q) begin
            // Next frame's object is loaded on the valid edge itself, so
            // the receiver sees it the very next cycle.
            frame_d    = frame_inc;
            pt_d       = '0;
            {x_d, y_d} = mem_q[frame_inc][0];
            state_d    = S_SEND;
          end else begin
            done_d      = 1'b1;
            dut_reset_d = 1'b1;
            busy_d      = 1'b0;
            state_d     = S_DONE;
          end
        end
`ifdef GEOFENCE_TIMEOUT_EN
        else if (wait_q == WCW'(TIMEOUT - 1)) begin
          err_d       = 1'b1;
          done_d      = 1'b1;
          dut_reset_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = S_DONE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
`endif
      end

      S_DONE: begin
        dut_reset_d = 1'b1;
        busy_d      = 1'b0;
        state_d     = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign X          = x_q;
  assign Y          = y_q;
  assign dut_reset  = dut_reset_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign result     = result_q;
  assign inside_cnt = inside_q;
  assign state_dbg  = state_q;
`ifdef GEOFENCE_TIMEOUT_EN
  assign err        = err_q;
`else
  assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_geofence_driver.sv
// tb_geofence_driver
// ----------------------------------------------------------------------------
// Directed sequence plus randomized runs for geofence_driver. The reference
// model is a plain point table per frame plus the expected result bits and
// inside count built from the receiver answers the bench chooses.
// ----------------------------------------------------------------------------
module tb_geofence_driver;

  localparam int TO = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [1:0] wr_frame;
  logic [2:0] wr_pt;
  logic [9:0] wr_x, wr_y;
  logic [1:0] num_frames_m1;
  logic       start;
  logic       busy;
  logic [9:0] X, Y;
  logic       dut_reset;
  logic       valid, is_inside;
  logic [3:0] result;
  logic [2:0] inside_cnt;
  logic       done;
  logic       err;
  logic [1:0] state_dbg;

  int total = 0;
  int bad   = 0;

  // Reference point table.
  logic [9:0] mx [4][7];
  logic [9:0] my [4][7];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  geofence_driver #(.TIMEOUT(TO)) dut (
    .clk           (clk),
    .reset         (reset),
    .wr_en         (wr_en),
    .wr_frame      (wr_frame),
    .wr_pt         (wr_pt),
    .wr_x          (wr_x),
    .wr_y          (wr_y),
    .num_frames_m1 (num_frames_m1),
    .start         (start),
    .busy          (busy),
    .X             (X),
    .Y             (Y),
    .dut_reset     (dut_reset),
    .valid         (valid),
    .is_inside     (is_inside),
    .result        (result),
    .inside_cnt    (inside_cnt),
    .done          (done),
    .err           (err),
    .state_dbg     (state_dbg)
  );

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_x"}, 32'(X), 32'd0);
    check({tag, "_y"}, 32'(Y), 32'd0);
    check({tag, "_dut_reset"}, 32'(dut_reset), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  // ---------------- driver tasks ----------------
  // Write one point; the model records it only for real point slots.
  task automatic wr(input int f, input int p, input logic [9:0] x, input logic [9:0] y);
    @(negedge clk);
    wr_en    = 1'b1;
    wr_frame = f[1:0];
    wr_pt    = p[2:0];
    wr_x     = x;
    wr_y     = y;
    @(negedge clk);
    wr_en = 1'b0;
    if (p != 7) begin
      mx[f][p] = x;
      my[f][p] = y;
    end
  endtask

  // One full run. With poke set, frame 0 also tries a write, a stray valid
  // during SEND and a stray start during WAIT, all of which must be ignored.
  task automatic run(input int nfm, input logic [3:0] ins, input bit poke);
    logic [3:0] exp_res;
    int         exp_cnt;
    int         d;
    exp_res = '0;
    exp_cnt = 0;
    @(negedge clk);
    start         = 1'b1;
    num_frames_m1 = nfm[1:0];
    @(negedge clk);
    start = 1'b0;
    for (int f = 0; f <= nfm; f++) begin
      for (int p = 0; p < 7; p++) begin
        if (p > 0) @(negedge clk);
        check($sformatf("f%0d_p%0d_x", f, p), 32'(X), 32'(mx[f][p]));
        check($sformatf("f%0d_p%0d_y", f, p), 32'(Y), 32'(my[f][p]));
        check("send_busy", 32'(busy), 32'd1);
        check("send_dut_reset", 32'(dut_reset), 32'd0);
        check("send_done", 32'(done), 32'd0);
        if (poke && f == 0) begin
          if (p == 2) begin
            wr_en = 1'b1; wr_frame = 2'd1; wr_pt = 3'd0;
            wr_x = 10'd999; wr_y = 10'd999;
            valid = 1'b1; is_inside = 1'b1;
          end else begin
            wr_en = 1'b0; valid = 1'b0; is_inside = 1'b0;
          end
        end
      end
      @(negedge clk);
      check("wait_x", 32'(X), 32'd0);
      check("wait_y", 32'(Y), 32'd0);
      check("wait_busy", 32'(busy), 32'd1);
      d = $urandom_range(0, 5);
      if (poke && f == 0) begin
        start = 1'b1;
        num_frames_m1 = 2'd3;
        d = 2;
      end
      for (int i = 0; i < d; i++) begin
        @(negedge clk);
        start = 1'b0;
        check("wait_hold_done", 32'(done), 32'd0);
        check("wait_hold_busy", 32'(busy), 32'd1);
      end
      start     = 1'b0;
      valid     = 1'b1;
      is_inside = ins[f];
      exp_res[f] = ins[f];
      exp_cnt   += int'(ins[f]);
      @(negedge clk);
      valid     = 1'b0;
      is_inside = 1'b0;
    end
    check("end_done", 32'(done), 32'd1);
    check("end_dut_reset", 32'(dut_reset), 32'd1);
    check("end_busy", 32'(busy), 32'd0);
    check("end_result", 32'(result), 32'(exp_res));
    check("end_inside_cnt", 32'(inside_cnt), 32'(exp_cnt));
    check("end_err", 32'(err), 32'd0);
    @(negedge clk);
    check_idle("after_done");
    check("after_result", 32'(result), 32'(exp_res));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] ins;
    int         nfm;
    reset = 1'b0; wr_en = 1'b0; wr_frame = '0; wr_pt = '0; wr_x = '0; wr_y = '0;
    num_frames_m1 = '0; start = 1'b0; valid = 1'b0; is_inside = 1'b0;
    for (int f = 0; f < 4; f++)
      for (int p = 0; p < 7; p++) begin
        mx[f][p] = '0;
        my[f][p] = '0;
      end

    // Reset state.
    repeat (2) @(negedge clk);
    check_idle("reset");
    check("reset_result", 32'(result), 32'd0);
    check("reset_inside_cnt", 32'(inside_cnt), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    reset = 1'b1;

    // Directed frame 0: square fence with object at its centre.
    wr(0, 0, 10'd50, 10'd50);
    wr(0, 1, 10'd0, 10'd0);
    wr(0, 2, 10'd100, 10'd0);
    wr(0, 3, 10'd100, 10'd100);
    wr(0, 4, 10'd0, 10'd100);
    wr(0, 5, 10'd20, 10'd120);
    wr(0, 6, 10'd10, 10'd110);
    run(0, 4'b0001, 1'b0);

    // Four frames alternating inside / outside.
    for (int f = 1; f < 4; f++)
      for (int p = 0; p < 7; p++)
        wr(f, p, 10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)));
    wr(2, 7, 10'd777, 10'd777);
    run(3, 4'b0101, 1'b0);

    // Write, valid and start while busy are all dropped.
    run(0, 4'b0000, 1'b1);
    run(1, 4'b0011, 1'b0);

    // Randomized runs.
    for (int k = 0; k < 5; k++) begin
      wr($urandom_range(0, 3), $urandom_range(0, 7),
         10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)));
      nfm = $urandom_range(0, 3);
      ins = 4'($urandom_range(0, 15));
      for (int f = nfm + 1; f < 4; f++) ins[f] = 1'b0;
      run(nfm, ins, 1'b0);
    end

    // Reset during SEND point 3.
    @(negedge clk);
    start = 1'b1; num_frames_m1 = 2'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_p3_x", 32'(X), 32'(mx[0][3]));
    reset = 1'b0;
    @(negedge clk);
    check_idle("mid_reset");
    check("mid_reset_result", 32'(result), 32'd0);
    reset = 1'b1;
    for (int f = 0; f < 4; f++)
      for (int p = 0; p < 7; p++) begin
        mx[f][p] = '0;
        my[f][p] = '0;
      end
    @(negedge clk);
    check_idle("mid_reset_hold");
    run(1, 4'b0010, 1'b0);

`ifdef GEOFENCE_TIMEOUT_EN
    // Receiver never answers.
    @(negedge clk);
    start = 1'b1; num_frames_m1 = 2'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("to_first_wait_busy", 32'(busy), 32'd1);
    for (int i = 0; i < TO - 1; i++) begin
      @(negedge clk);
      check("to_wait_done", 32'(done), 32'd0);
    end
    @(negedge clk);
    check("to_done", 32'(done), 32'd1);
    check("to_err", 32'(err), 32'd1);
    check("to_dut_reset", 32'(dut_reset), 32'd1);
    check("to_result", 32'(result), 32'd0);
    @(negedge clk);
    check_idle("to_idle");
    check("to_err_sticky", 32'(err), 32'd1);
    @(negedge clk);
    start = 1'b1; num_frames_m1 = 2'd0;
    @(negedge clk);
    start = 1'b0;
    check("to_err_cleared", 32'(err), 32'd0);
    repeat (7) @(negedge clk);
    valid = 1'b1; is_inside = 1'b1;
    @(negedge clk);
    valid = 1'b0; is_inside = 1'b0;
    check("to_rerun_done", 32'(done), 32'd1);
    check("to_rerun_result", 32'(result), 32'd1);
`endif

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/geofence_driver.md
GEOFENCE_DRIVER -- requirements
Module: geofence_driver

Interface
REQ-001 SHALL have parameter TIMEOUT, default 32: cycles allowed in WAIT before abort (used only with GEOFENCE_TIMEOUT_EN).
REQ-002 SHALL have clk  input  1: single clock; all logic on its rising edge.
REQ-003 SHALL have reset  input  1: synchronous, active-low reset.
REQ-004 SHALL have wr_en  input  1: frame-memory write strobe.
REQ-005 SHALL have wr_frame  input  2: frame index 0..3.
REQ-006 SHALL have wr_pt  input  3: 0 = object point, 1..6 = fence vertices 0..5; 7 is ignored.
REQ-007 SHALL have wr_x, wr_y  input  10 each: point coordinates.
REQ-008 SHALL have num_frames_m1  input  2: number of frames to run, minus 1; sampled with start.
REQ-009 SHALL have start  input  1: begin a run.
REQ-010 SHALL have busy  output  1: high in SEND and WAIT.
REQ-011 SHALL have X, Y  output  10 each: point stream to the geofence receiver.
REQ-012 SHALL have dut_reset  output  1: active-high reset to the receiver.
REQ-013 SHALL have valid, is_inside  input  1 each: result handshake from the receiver.
REQ-014 SHALL have result  output  4: bit f = is_inside of frame f.
REQ-015 SHALL have inside_cnt  output  3: number of frames judged inside.
REQ-016 SHALL have done  output  1: one-cycle pulse at end of run.
REQ-017 SHALL have err  output  1: sticky timeout flag, cleared by start.

Function
REQ-018 SHALL store 4 frames x 7 points x 20 bits in registers, written on the clock edge where wr_en=1 and the state is IDLE; writes in other states are dropped.
REQ-019 SHALL implement states IDLE, SEND, WAIT and DONE, all outputs registered.
REQ-020 IDLE: dut_reset=1, X=Y=0; when start=1, SHALL clear result, inside_cnt and err, latch num_frames_m1, set frame=0, pt=0, load X/Y with frame 0 point 0, drive dut_reset 0, and enter SEND.
REQ-021 SEND: SHALL present points 0..6 of the current frame on 7 consecutive cycles, one point per cycle, with no gaps; after point 6, SHALL drive X=Y=0 and enter WAIT.
REQ-022 WAIT: on the edge where valid=1, SHALL write result[frame] with is_inside and increment inside_cnt if is_inside=1.
REQ-023 On that valid edge, if frame < latched count, the driver SHALL increment frame and load point 0 of the next frame, so the receiver samples it in the cycle right after valid, then enter SEND.
REQ-024 On that valid edge, if frame equals the latched count, the driver SHALL enter DONE.
REQ-025 DONE: SHALL pulse done=1 for exactly one cycle, set dut_reset=1, and return to IDLE.
REQ-026 SHALL ignore valid=1 outside WAIT, and SHALL ignore start outside IDLE.
REQ-027 Back-to-back frames SHALL have zero idle cycles between the valid of one frame and point 0 of the next.

Reset
REQ-028 With reset=0 on an edge, SHALL enter IDLE with X=Y=0, dut_reset=1, busy=0, done=0, err=0, result=0, inside_cnt=0; frame memory SHALL be cleared to 0.
REQ-029 Reset asserted mid-run SHALL abort without a done pulse and take effect on the same edge.

Configuration
REQ-030 With GEOFENCE_TIMEOUT_EN defined, a WAIT counter SHALL count cycles; reaching TIMEOUT without valid SHALL set err=1, pulse done, assert dut_reset and return to IDLE with the remaining result bits at 0.
REQ-031 Without GEOFENCE_TIMEOUT_EN, WAIT SHALL last until valid, and err SHALL be tied to 0.

Verification
REQ-032 Frame 0: object (50,50), vertices (0,0),(100,0),(100,100),(0,100),(20,120),(10,110); num_frames_m1=0; start -> X/Y shows the 7 points on 7 consecutive cycles, then valid from a receiver model -> result[0]=1, inside_cnt=1, done pulses once.
REQ-033 Four frames whose objects alternate inside/outside, num_frames_m1=3 -> result=4'b0101, inside_cnt=2, and each next point 0 appears in the cycle after valid.
REQ-034 Writing during SEND (frame 1, point 0 = (999,999)) -> the stored point is unchanged, checked on the next run.
REQ-035 With GEOFENCE_TIMEOUT_EN and TIMEOUT=32, never assert valid -> after 32 WAIT cycles, err=1, done pulses, dut_reset=1.
REQ-036 Assert reset low during SEND point 3 -> next cycle IDLE, X=Y=0, dut_reset=1, no done pulse; a following start completes normally.
